// File: rtl/game_io_pkg.sv
// Shared definitions for the game-input path: PS/2 packet FSM states, screen limits,
// field widths and the header-byte layout.
package game_io_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } mouseState_t;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int POS_W        = 11;
    localparam int DELTA_W      = 9;

    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Header byte minus the always-one sync bit, which is only needed on arrival.
    typedef struct packed {
        logic       yOvf;
        logic       xOvf;
        logic       ySign;
        logic       xSign;
        logic [2:0] buttons;
    } mouseHeader_t;

endpackage

// File: rtl/axis_accum_clamp.sv
// One cursor axis: adds (or subtracts) a signed PS/2 delta and clamps to [0, MAX].
// Build with PS2_MOUSE_ACCEL_EN defined to double deltas whose magnitude exceeds 8.
module axis_accum_clamp
    import game_io_pkg::*;
#(
    parameter int MAX = SCREEN_X_MAX
) (
    input  logic        [POS_W-1:0]   pos,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      negate,
    output logic        [POS_W-1:0]   nextPos
);

    localparam int SUM_W = 13;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

    logic signed [SUM_W-1:0] posExt;
    logic signed [SUM_W-1:0] step;
    logic signed [SUM_W-1:0] sum;

    assign posExt = {{(SUM_W-POS_W){1'b0}}, pos};

`ifdef PS2_MOUSE_ACCEL_EN
    // One extra bit holds the doubled magnitude of the most negative 9-bit delta.
    logic signed [DELTA_W:0] scaled;

    always_comb begin
        scaled = {delta[DELTA_W-1], delta};
        if (delta > 9'sd8 || delta < -9'sd8) begin
            scaled = scaled <<< 1;
        end
    end

    assign step = {{(SUM_W-DELTA_W-1){scaled[DELTA_W]}}, scaled};
`else
    assign step = {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta};
`endif

    always_comb begin
        sum = negate ? (posExt - step) : (posExt + step);
        if (sum < 13'sd0) begin
            nextPos = '0;
        end else if (sum > MAX_S) begin
            nextPos = POS_W'(MAX);
        end else begin
            nextPos = sum[POS_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// Turns the PS/2 mouse byte stream into a clamped absolute cursor and button word.
// Optional delta acceleration is selected with PS2_MOUSE_ACCEL_EN (see axis_accum_clamp).
module ps2_mouse_tracker
    import game_io_pkg::*;
#(
    parameter int X_MAX          = SCREEN_X_MAX,
    parameter int Y_MAX          = SCREEN_Y_MAX,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             rx_err,
    output logic [POS_W-1:0] rx,
    output logic [POS_W-1:0] ry,
    output logic [3:0]       var_word,   // "var" is a reserved word
    output logic             pkt_valid,
    output logic             sync_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mouseState_t  stateReg, stateNext;
    mouseHeader_t b0Reg, b0Next;
    logic [7:0]   b1Reg, b1Next;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic apply;
    logic abort;

    logic signed [DELTA_W-1:0] dx, dy;
    logic [POS_W-1:0] nextX, nextY;

    always_comb begin
        stateNext = stateReg;
        b0Next    = b0Reg;
        b1Next    = b1Reg;
        cntNext   = '0;
        apply     = 1'b0;
        abort     = 1'b0;
        case (stateReg)
            WAIT_B0: begin
                if (rx_valid && !rx_err && rx_byte[SYNC]) begin
                    b0Next    = '{yOvf: rx_byte[YOVF], xOvf: rx_byte[XOVF],
                                  ySign: rx_byte[YSIGN], xSign: rx_byte[XSIGN],
                                  buttons: rx_byte[2:0]};
                    stateNext = WAIT_B1;
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (rx_err) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    if (stateReg == WAIT_B1) begin
                        b1Next    = rx_byte;
                        stateNext = WAIT_B2;
                    end else begin
                        apply     = 1'b1;
                        stateNext = WAIT_B0;
                    end
                end else if (cntReg == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            default: stateNext = WAIT_B0;
        endcase
        if (abort) begin
            stateNext = WAIT_B0;
        end
    end

    // The third byte is consumed straight off the bus so the cursor lands one clock later.
    assign dx = b0Reg.xOvf ? '0 : {b0Reg.xSign, b1Reg};
    assign dy = b0Reg.yOvf ? '0 : {b0Reg.ySign, rx_byte};

    axis_accum_clamp #(.MAX(X_MAX)) xAxis (
        .pos     (rx),
        .delta   (dx),
        .negate  (1'b0),
        .nextPos (nextX)
    );

    axis_accum_clamp #(.MAX(Y_MAX)) yAxis (
        .pos     (ry),
        .delta   (dy),
        .negate  (1'b1),
        .nextPos (nextY)
    );

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            stateReg  <= WAIT_B0;
            b0Reg     <= '0;
            b1Reg     <= '0;
            cntReg    <= '0;
            rx        <= POS_W'(X_INIT);
            ry        <= POS_W'(Y_INIT);
            var_word  <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            b0Reg     <= b0Next;
            b1Reg     <= b1Next;
            cntReg    <= cntNext;
            pkt_valid <= apply;
            sync_err  <= abort;
            if (apply) begin
                rx       <= nextX;
                ry       <= nextY;
                var_word <= {1'b0, b0Reg.buttons};
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: stimulus pushes expected events from a
// packet-level model, a negedge monitor pops and compares whenever the DUT pulses.
module tb_ps2_mouse_tracker;

    localparam int TO = 100;
    localparam int XM = 639;
    localparam int YM = 479;
    localparam int XI = 320;
    localparam int YI = 240;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [10:0] rx, ry;
    logic [3:0]  var_word;
    logic        pkt_valid, sync_err;

    ps2_mouse_tracker #(
        .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .rx         (rx),
        .ry         (ry),
        .var_word   (var_word),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit isPkt;
        int x;
        int y;
        int v;
        int minC;
        int maxC;
    } ev_t;

    ev_t        expQ[$];
    logic [7:0] pend[$];
    int mx = XI, my = YI;
    int holdX = XI, holdY = YI, holdV = 0;
    int lastC = 0;
    int checks = 0, failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampI(input int v, input int m);
        if (v < 0) return 0;
        if (v > m) return m;
        return v;
    endfunction

    function automatic int decode(input bit sgn, input bit ovf, input logic [7:0] b);
        int d;
        if (ovf) return 0;
        d = sgn ? int'(b) - 256 : int'(b);
`ifdef PS2_MOUSE_ACCEL_EN
        if (d > 8 || d < -8) d = d * 2;
`endif
        return d;
    endfunction

    // Drive one receiver strobe for a cycle and advance the packet model.
    task automatic drive(input logic [7:0] b, input bit v, input bit e);
        int c;
        int dx, dy;
        ev_t ev;
        c = cyc;
        rx_byte  = b;
        rx_valid = v;
        rx_err   = e;
        if (e) begin
            if (pend.size() > 0) begin
                pend.delete();
                ev = '{0, 0, 0, 0, c + 1, c + 1};
                expQ.push_back(ev);
            end
        end else if (v) begin
            if (pend.size() > 0 || b[3]) begin
                pend.push_back(b);
                lastC = c + 1;
            end
            if (pend.size() == 3) begin
                dx = decode(pend[0][4], pend[0][6], pend[1]);
                dy = decode(pend[0][5], pend[0][7], pend[2]);
                mx = clampI(mx + dx, XM);
                my = clampI(my - dy, YM);
                ev = '{1, mx, my, int'(pend[0][2:0]), c + 1, c + 1};
                expQ.push_back(ev);
                pend.delete();
            end
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        drive(a, 1'b1, 1'b0);
        drive(b, 1'b1, 1'b0);
        drive(c, 1'b1, 1'b0);
    endtask

    // Idle long enough to expire a partial packet: one sync_err expected near TO cycles.
    task automatic idle(input int n);
        ev_t ev;
        if (pend.size() > 0 && n >= TO + 5) begin
            ev = '{0, 0, 0, 0, lastC + TO - 1, lastC + TO + 1};
            expQ.push_back(ev);
            pend.delete();
        end
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        mx = XI;
        my = YI;
        pend.delete();
        holdX = XI;
        holdY = YI;
        holdV = 0;
        ctrl_reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
    endtask

    // Monitor: compare on every pulse, otherwise outputs must hold.
    ev_t mev;
    always @(negedge clock) begin
        if (pkt_valid || sync_err) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event pkt_valid=%0b sync_err=%0b required=none (cycle %0d)",
                         pkt_valid, sync_err, cyc);
            end else begin
                mev = expQ.pop_front();
                check("event_kind", int'({pkt_valid, sync_err}), mev.isPkt ? 2 : 1);
                checks++;
                if (cyc < mev.minC || cyc > mev.maxC) begin
                    failures++;
                    $display("FAIL event_cycle actual=%0d required=%0d..%0d", cyc, mev.minC, mev.maxC);
                end
                if (mev.isPkt) begin
                    check("pkt_rx", int'(rx), mev.x);
                    check("pkt_ry", int'(ry), mev.y);
                    check("pkt_var", int'(var_word), mev.v);
                    holdX = mev.x;
                    holdY = mev.y;
                    holdV = mev.v;
                end else begin
                    check("err_rx_hold", int'(rx), holdX);
                    check("err_ry_hold", int'(ry), holdY);
                end
            end
        end else begin
            check("hold_rx", int'(rx), holdX);
            check("hold_ry", int'(ry), holdY);
            check("hold_var", int'(var_word), holdV);
        end
    end

    initial begin
        @(posedge clock);
        #1;
        doReset();
        check("reset_rx", int'(rx), 320);
        check("reset_ry", int'(ry), 240);
        check("reset_var", int'(var_word), 0);
        check("reset_pulses", int'({pkt_valid, sync_err}), 0);

        pkt(8'h09, 8'h0A, 8'h05);
        idle(3);
`ifndef PS2_MOUSE_ACCEL_EN
        check("basic_rx", int'(rx), 330);
        check("basic_ry", int'(ry), 235);
`endif
        check("basic_var", int'(var_word), 1);

        doReset();
        pkt(8'h18, 8'h00, 8'h00);
        idle(2);
        pkt(8'h18, 8'h00, 8'h00);
        idle(3);
        check("clamp_low_rx", int'(rx), 0);
        check("clamp_low_ry", int'(ry), 240);

        doReset();
        drive(8'h00, 1'b1, 1'b0);
        pkt(8'h0A, 8'h01, 8'h00);
        idle(3);
        check("resync_rx", int'(rx), 321);
        check("resync_var", int'(var_word), 2);

        doReset();
        drive(8'h08, 1'b1, 1'b0);
        idle(TO + 10);
        pkt(8'h08, 8'h02, 8'h00);
        idle(3);
`ifndef PS2_MOUSE_ACCEL_EN
        check("after_timeout_rx", int'(rx), 322);
`endif
        drive(8'h08, 1'b1, 1'b0);
        drive(8'h7F, 1'b1, 1'b0);
        idle(TO + 10);

        pkt(8'h4C, 8'h10, 8'h10);
        idle(2);
        drive(8'h08, 1'b1, 1'b0);
        drive(8'h05, 1'b1, 1'b1);
        drive(8'h05, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h08, 1'b1, 1'b1);
        idle(3);

        drive(8'h08, 1'b1, 1'b0);
        drive(8'h40, 1'b1, 1'b0);
        idle(2);
        doReset();
        pkt(8'h08, 8'h7F, 8'h80);
        pkt(8'h08, 8'h7F, 8'h80);
        pkt(8'h08, 8'hFF, 8'h80);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            b = 8'($urandom);
            if (pend.size() == 0 && r < 90) b[3] = 1'b1;
            if (r >= 95) drive(b, 1'($urandom_range(0, 1)), 1'b1);
            else         drive(b, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        check("events_outstanding", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
